// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: receiver state
// encoding and the baud divider calculation used by both directions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Integer division, clamped so a silly BAUD never produces a zero-length bit.
    function automatic int clks_per_bit(input int sys_clk, input int baud);
        int q;
        q = (baud > 0) ? (sys_clk / baud) : 1;
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen per signal so an idle line does not look like an event after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: recovers start/data/stop frames from rx_wire
// and presents each good word with a one-cycle valid strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for rx_s low while enabled
// START | timing to mid start bit, then confirm it is still low
// DATA  | sampling one data bit every CLKS_PER_BIT cycles, LSB first
// STOP  | sampling mid stop bit; high -> valid, low -> frame_error
// BREAK | line held low after a bad stop bit, waiting for it to rise
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_output,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    // The IDLE->START edge is already one cycle into the start bit, so the
    // start check lands exactly HALF_BIT edges after rx_s falls.
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'((HALF_BIT > 1) ? HALF_BIT - 2 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_wire),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_output   <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            valid       <= 1'b0;
            frame_error <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == HALF_END) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_END) begin
                            cnt            <= '0;
                            shift[bit_idx] <= rx_s;
                            if (bit_idx == LAST_IDX) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_END) begin
                            cnt <= '0;
                            if (rx_s) begin
                                rx_output <= shift;
                                valid     <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                frame_error <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    BREAK: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(valid && frame_error));

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= BIT_END);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int SYS_CLK   = 10_000_000;
    localparam int BAUD      = 476_190;
    localparam int CLK_NS    = 100;
    localparam int CPB       = SYS_CLK / BAUD;
    localparam int HALF      = CPB / 2;
    localparam int BIT_NS    = CPB * CLK_NS;
    // rx_wire edge -> rx_s low takes 2 edges; stop sample is HALF+(DATA_BITS+1)*CPB later.
    localparam int EXP_LAT   = HALF + (DATA_BITS + 1) * CPB + 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 rx_wire = 1'b1;
    logic [DATA_BITS-1:0] rx_output;
    logic                 valid;
    logic                 frame_error;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .BAUD      (BAUD),
        .SYS_CLK   (SYS_CLK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx_wire     (rx_wire),
        .rx_output   (rx_output),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #(CLK_NS / 2) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation only: counts and records pulses, sampled on the falling edge.
    int                   n_valid = 0;
    int                   n_fe = 0;
    int                   v_run = 0;
    int                   f_run = 0;
    int                   run_err = 0;
    int                   both_err = 0;
    int                   last_valid_cyc = 0;
    logic [DATA_BITS-1:0] got[$];

    always @(negedge clk) begin
        if (valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            got.push_back(rx_output);
        end
        if (frame_error) n_fe <= n_fe + 1;
        v_run <= valid ? v_run + 1 : 0;
        f_run <= frame_error ? f_run + 1 : 0;
        if ((valid && v_run >= 1) || (frame_error && f_run >= 1)) run_err <= run_err + 1;
        if (valid && frame_error) both_err <= both_err + 1;
    end

    task automatic align();
        @(posedge clk);
        #30;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
        rx_wire = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_wire = d[i];
            #(bit_ns);
        end
        rx_wire = stop;
        #(bit_ns);
        rx_wire = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        rx_wire = 1'b1;
        repeat (3) @(posedge clk);
        #30;
        n_checks++;
        if (rx_output !== 8'h00) begin n_fail++; $display("FAIL reset_rx_output got=%h exp=00", rx_output); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_checks++;
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got=%b exp=0", frame_error); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single();
        int n0, f0, t0, lat;
        align();
        n0 = n_valid; f0 = n_fe; t0 = cyc;
        send_frame(8'hA5, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        lat = last_valid_cyc - t0;
        n_checks++;
        if (n_valid - n0 !== 1) begin n_fail++; $display("FAIL single_valid_count got=%0d exp=1", n_valid - n0); end
        n_checks++;
        if (rx_output !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", rx_output); end
        n_checks++;
        if (n_fe - f0 !== 0) begin n_fail++; $display("FAIL single_frame_error got=%0d exp=0", n_fe - f0); end
        n_checks++;
        if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
            n_fail++; $display("FAIL single_latency got=%0d exp=%0d+-1", lat, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat[3];
        int n0, g0;
        pat[0] = 8'h00; pat[1] = 8'h81; pat[2] = 8'hFF;
        align();
        n0 = n_valid; g0 = got.size();
        for (int i = 0; i < 3; i++) send_frame(pat[i], 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_checks++;
        if (n_valid - n0 !== 3) begin n_fail++; $display("FAIL b2b_valid_count got=%0d exp=3", n_valid - n0); end
        for (int i = 0; i < 3; i++) begin
            if (g0 + i < got.size()) begin
                n_checks++;
                if (got[g0 + i] !== pat[i]) begin
                    n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got[g0 + i], pat[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] prev;
        int n0, f0;
        align();
        prev = rx_output; n0 = n_valid; f0 = n_fe;
        rx_wire = 1'b0;
        #200;
        rx_wire = 1'b1;
        #(5 * CLK_NS - 200);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", busy); end
        #((HALF + 2) * CLK_NS);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_back_idle got=%b exp=0", busy); end
        #(BIT_NS);
        n_checks++;
        if (n_valid - n0 !== 0 || n_fe - f0 !== 0) begin
            n_fail++; $display("FAIL glitch_pulses valid=%0d fe=%0d exp=0/0", n_valid - n0, n_fe - f0);
        end
        n_checks++;
        if (rx_output !== prev) begin n_fail++; $display("FAIL glitch_rx_output got=%h exp=%h", rx_output, prev); end
    endtask

    task automatic test_frame_error();
        logic [7:0] prev, d;
        int n0, f0;
        d = 8'h3C;
        align();
        prev = rx_output; n0 = n_valid; f0 = n_fe;
        rx_wire = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_wire = d[i];
            #(BIT_NS);
        end
        rx_wire = 1'b0;
        #(40 * BIT_NS);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held got=%b exp=1", busy); end
        n_checks++;
        if (n_fe - f0 !== 1) begin n_fail++; $display("FAIL ferr_count got=%0d exp=1", n_fe - f0); end
        n_checks++;
        if (n_valid - n0 !== 0) begin n_fail++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - n0); end
        n_checks++;
        if (rx_output !== prev) begin n_fail++; $display("FAIL ferr_rx_output got=%h exp=%h", rx_output, prev); end
        rx_wire = 1'b1;
        #(6 * CLK_NS);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy got=%b exp=0", busy); end
        #(BIT_NS);
        n_checks++;
        if (n_fe - f0 !== 1) begin n_fail++; $display("FAIL ferr_count_after got=%0d exp=1", n_fe - f0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int n0;
        d = 8'h96;
        align();
        rx_wire = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx_wire = d[i];
            #(BIT_NS);
        end
        rx_wire = d[3];
        #(BIT_NS / 2);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rx_output !== 8'h00 || valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got=%h/%b/%b/%b exp=00/0/0/0", rx_output, valid, frame_error, busy);
        end
        rx_wire = 1'b1;
        #(BIT_NS);
        rst_n = 1'b1;
        #(2 * BIT_NS);
        align();
        n0 = n_valid;
        send_frame(8'h5A, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_checks++;
        if (n_valid - n0 !== 1) begin n_fail++; $display("FAIL rst_mid_valid got=%0d exp=1", n_valid - n0); end
        n_checks++;
        if (rx_output !== 8'h5A) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=5a", rx_output); end
    endtask

    task automatic test_enable();
        logic [7:0] d;
        int n0, f0;
        d = 8'h3C;
        align();
        n0 = n_valid; f0 = n_fe;
        rx_wire = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 5; i++) begin
            rx_wire = d[i];
            #(BIT_NS);
        end
        enable  = 1'b0;
        rx_wire = 1'b1;
        #(3 * CLK_NS);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_abort_busy got=%b exp=0", busy); end
        #(2 * BIT_NS);
        enable = 1'b1;
        #(12 * BIT_NS);
        n_checks++;
        if (n_valid - n0 !== 0 || n_fe - f0 !== 0) begin
            n_fail++; $display("FAIL enable_abort_pulses valid=%0d fe=%0d exp=0/0", n_valid - n0, n_fe - f0);
        end
        align();
        send_frame(8'h81, 1'b1, BIT_NS);
        #(2 * BIT_NS);
        n_checks++;
        if (n_valid - n0 !== 1) begin n_fail++; $display("FAIL enable_resume_valid got=%0d exp=1", n_valid - n0); end
        n_checks++;
        if (rx_output !== 8'h81) begin n_fail++; $display("FAIL enable_resume_data got=%h exp=81", rx_output); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe, g0, f0, n_frames;
        logic [7:0] d;
        logic stop;
        int gap, bit_ns;
        exp_fe = 0;
        n_frames = 24;
        align();
        g0 = got.size(); f0 = n_fe;
        for (int i = 0; i < n_frames; i++) begin
            d      = 8'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 5) != 0);
            gap    = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
            bit_ns = BIT_NS + (int'($urandom_range(0, 4)) - 2) * 21;
            if (stop) exp_q.push_back(d);
            else exp_fe++;
            send_frame(d, stop, bit_ns);
            #(gap * bit_ns);
        end
        #(3 * BIT_NS);
        n_checks++;
        if (got.size() - g0 !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_valid_count got=%0d exp=%0d", got.size() - g0, exp_q.size());
        end
        n_checks++;
        if (n_fe - f0 !== exp_fe) begin n_fail++; $display("FAIL rand_fe_count got=%0d exp=%0d", n_fe - f0, exp_fe); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (g0 + i < got.size()) begin
                n_checks++;
                if (got[g0 + i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got[g0 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_pulse_rules();
        n_checks++;
        if (run_err !== 0) begin n_fail++; $display("FAIL pulse_width long_pulses=%0d exp=0", run_err); end
        n_checks++;
        if (both_err !== 0) begin n_fail++; $display("FAIL pulse_exclusive overlaps=%0d exp=0", both_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid();
        test_enable();
        test_random();
        test_pulse_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
